fitness_eval: RTL and testbench

Sequential fitness evaluator that sits directly downstream of the combinational evolvable circuit. It drives every input vector onto the circuit's `chromIn` port and samples `chromOut` after a programmable settle time. Each output bit is compared against a target truth table, and the number of matching bits is accumulated into a fitness score. A start/done handshake reports the result to the genetic-algorithm controller.

---
 rtl/fitness_pkg.sv | 31 +++
 rtl/fitness_eval_match_count.sv | 25 ++
 rtl/fitness_eval.sv | 161 ++++++++++++++++
 tb/tb_fitness_eval.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fitness_pkg.sv
// Shared types and width helpers for the fitness evaluator.
package fitness_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } fe_state_t;

  // Number of truth-table rows for an n_in-bit circuit input.
  function automatic int n_rows(input int n_in);
    return 1 << n_in;
  endfunction

  // Total number of truth-table bits compared per evaluation.
  function automatic int n_bits(input int n_in, input int n_out);
    return n_rows(n_in) * n_out;
  endfunction

  // Width of a score that must hold 0..n_bits inclusive.
  function automatic int fw(input int n_in, input int n_out);
    return $clog2(n_bits(n_in, n_out) + 1);
  endfunction

  // Width of the settle wait counter (counts 0..settle-1, at least 1 bit).
  function automatic int wait_w(input int settle);
    return (settle < 2) ? 1 : $clog2(settle);
  endfunction

endpackage

// File: rtl/fitness_eval_match_count.sv
// Combinational popcount of chrom_out XNOR the target row for one truth-table row.
module match_count
  import fitness_pkg::*;
#(
  parameter int N_OUT = 1,
  parameter int CW    = $clog2(N_OUT + 1)
) (
  input  logic [N_OUT-1:0] chrom_out,
  input  logic [N_OUT-1:0] target_row,
  output logic [CW-1:0]    count
);

  logic [N_OUT-1:0] hit;

  assign hit = ~(chrom_out ^ target_row);

  // Count the output bits that agree with the target row.
  always_comb begin
    count = '0;
    for (int j = 0; j < N_OUT; j++) begin
      count = count + CW'(hit[j]);
    end
  end

endmodule

// File: rtl/fitness_eval.sv
// Sequential fitness evaluator: sweeps every input vector through a combinational
// circuit, waits SETTLE_CYCLES, samples the response and scores it against a
// target truth table.
// Optional feature macro: FITNESS_MASK_EN adds the mismatch_mask output.
//
// Handshake: start is a request accepted only on a cycle where busy=0 (IDLE);
// requests while busy are dropped, not queued. busy rises the cycle after the
// accepted start and stays high through the single-cycle done pulse; fitness,
// perfect (and mismatch_mask) are valid from done onward and hold until the
// next done.
module fitness_eval
  import fitness_pkg::*;
#(
  parameter int N_IN          = 2,
  parameter int N_OUT         = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [n_bits(N_IN,N_OUT)-1:0] target,
  output logic [N_IN-1:0]               chrom_in,
  input  logic [N_OUT-1:0]              chrom_out,
  output logic                          busy,
  output logic                          done,
  output logic [fw(N_IN,N_OUT)-1:0]     fitness,
  output logic                          perfect,
`ifdef FITNESS_MASK_EN
  output logic [n_bits(N_IN,N_OUT)-1:0] mismatch_mask,
`endif
  output fe_state_t                     dbg_state
);

  localparam int N_ROWS = n_rows(N_IN);
  localparam int N_BITS = n_bits(N_IN, N_OUT);
  localparam int FW     = fw(N_IN, N_OUT);
  localparam int CW     = $clog2(N_OUT + 1);
  localparam int WW     = wait_w(SETTLE_CYCLES);
  localparam int RW     = N_IN + 1;

  // Row counter is one bit wider than chrom_in so the last-row compare never wraps.
  localparam logic [RW-1:0] LAST_ROW  = RW'(N_ROWS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [FW-1:0] FIT_MAX   = FW'(N_BITS);

  fe_state_t         state_q;
  logic [RW-1:0]     row_q;
  logic [WW-1:0]     wait_q;
  logic [N_BITS-1:0] tgt_q;
  logic [FW-1:0]     acc_q;
  logic [FW-1:0]     acc_next;
  logic [N_OUT-1:0]  row_tgt;
  logic [CW-1:0]     row_cnt;

  assign dbg_state = state_q;

  // Select the latched target bits belonging to the current row.
  always_comb begin
    row_tgt = '0;
    for (int v = 0; v < N_ROWS; v++) begin
      if (row_q == RW'(v)) row_tgt = tgt_q[v*N_OUT +: N_OUT];
    end
  end

  match_count #(
    .N_OUT (N_OUT),
    .CW    (CW)
  ) u_match_count (
    .chrom_out  (chrom_out),
    .target_row (row_tgt),
    .count      (row_cnt)
  );

  assign acc_next = acc_q + FW'(row_cnt);

`ifdef FITNESS_MASK_EN
  logic [N_BITS-1:0] mask_q;
  logic [N_BITS-1:0] mask_next;

  // Record which bits of the current row disagree with the target.
  always_comb begin
    mask_next = mask_q;
    for (int v = 0; v < N_ROWS; v++) begin
      if (row_q == RW'(v)) mask_next[v*N_OUT +: N_OUT] = chrom_out ^ row_tgt;
    end
  end
`endif

  // Evaluation FSM: sweep rows, accumulate matches, publish on done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      wait_q   <= '0;
      tgt_q    <= '0;
      acc_q    <= '0;
      chrom_in <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fitness  <= '0;
      perfect  <= 1'b0;
`ifdef FITNESS_MASK_EN
      mask_q        <= '0;
      mismatch_mask <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            tgt_q    <= target;
            acc_q    <= '0;
            chrom_in <= '0;
            row_q    <= '0;
            wait_q   <= '0;
            busy     <= 1'b1;
`ifdef FITNESS_MASK_EN
            mask_q   <= '0;
`endif
            state_q  <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
          end
        end
        SETTLE: begin
          if (wait_q == WAIT_LAST) begin
            wait_q  <= '0;
            state_q <= SAMPLE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        SAMPLE: begin
          acc_q <= acc_next;
`ifdef FITNESS_MASK_EN
          mask_q <= mask_next;
`endif
          if (row_q == LAST_ROW) begin
            state_q  <= DONE;
            done     <= 1'b1;
            fitness  <= acc_next;
            perfect  <= (acc_next == FIT_MAX);
            chrom_in <= '0;
`ifdef FITNESS_MASK_EN
            mismatch_mask <= mask_next;
`endif
          end else begin
            row_q    <= row_q + 1'b1;
            chrom_in <= chrom_in + 1'b1;
            state_q  <= (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fitness_eval.sv
// Testbench for fitness_eval: instance A uses defaults (N_IN=2, N_OUT=1,
// SETTLE_CYCLES=2), instance B uses N_OUT=2 with SETTLE_CYCLES=0.
// Build with FITNESS_MASK_EN defined to also check mismatch_mask.
module tb_fitness_eval;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- instance A signals ----------------
  logic       a_start = 1'b0;
  logic [3:0] a_target = '0;
  logic [1:0] a_chrom_in;
  logic       a_chrom_out;
  logic       a_busy, a_done, a_perfect;
  logic [2:0] a_fitness;
  logic [3:0] a_lut = '0;
  fitness_pkg::fe_state_t a_state;
`ifdef FITNESS_MASK_EN
  logic [3:0] a_mask;
`endif

  // ---------------- instance B signals ----------------
  logic       b_start = 1'b0;
  logic [7:0] b_target = '0;
  logic [1:0] b_chrom_in;
  logic [1:0] b_chrom_out;
  logic       b_busy, b_done, b_perfect;
  logic [3:0] b_fitness;
  logic [7:0] b_lut = '0;
  fitness_pkg::fe_state_t b_state;
`ifdef FITNESS_MASK_EN
  logic [7:0] b_mask;
`endif

  // The "evolvable circuit": a lookup table indexed by chrom_in.
  assign a_chrom_out = a_lut[a_chrom_in];
  assign b_chrom_out = 2'(b_lut >> (32'(b_chrom_in) * 2));

  fitness_eval #(.N_IN(2), .N_OUT(1), .SETTLE_CYCLES(2)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .start     (a_start),
    .target    (a_target),
    .chrom_in  (a_chrom_in),
    .chrom_out (a_chrom_out),
    .busy      (a_busy),
    .done      (a_done),
    .fitness   (a_fitness),
    .perfect   (a_perfect),
`ifdef FITNESS_MASK_EN
    .mismatch_mask (a_mask),
`endif
    .dbg_state (a_state)
  );

  fitness_eval #(.N_IN(2), .N_OUT(2), .SETTLE_CYCLES(0)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .start     (b_start),
    .target    (b_target),
    .chrom_in  (b_chrom_in),
    .chrom_out (b_chrom_out),
    .busy      (b_busy),
    .done      (b_done),
    .fitness   (b_fitness),
    .perfect   (b_perfect),
`ifdef FITNESS_MASK_EN
    .mismatch_mask (b_mask),
`endif
    .dbg_state (b_state)
  );

  // ---------------- scoreboard helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + compare, instance A ----------------
  // a_ph = 0 when idle, else the cycle number since the edge that accepted start.
  // Rows span cycles 1..4*(S+1), each row S+1 cycles; done is cycle 4*(S+1)+1.
  int         a_ph = 0;
  logic [3:0] a_tl = '0, a_ll = '0, a_emask = '0;
  int         a_efit = 0;
  logic       a_eperf = 1'b0;

  always @(negedge clk) begin : cmp_a
    int l_len;
    int e_chrom;
    l_len = 4 * 3;
    if (rst) begin
      a_ph = 0; a_efit = 0; a_eperf = 1'b0; a_emask = '0;
    end else if (a_ph == l_len + 1) begin
      a_emask = a_ll ^ a_tl;
      a_efit  = 4 - $countones(a_emask);
      a_eperf = (a_efit == 4);
    end
    e_chrom = (a_ph >= 1 && a_ph <= l_len) ? (a_ph - 1) / 3 : 0;
    check("a_chrom_in", 32'(a_chrom_in), e_chrom);
    check("a_busy", 32'(a_busy), 32'(a_ph != 0));
    check("a_done", 32'(a_done), 32'(a_ph == l_len + 1));
    check("a_fitness", 32'(a_fitness), a_efit);
    check("a_perfect", 32'(a_perfect), 32'(a_eperf));
    check("a_state_idle", 32'(a_state == fitness_pkg::IDLE), 32'(a_ph == 0));
`ifdef FITNESS_MASK_EN
    check("a_mask", 32'(a_mask), 32'(a_emask));
`endif
    if (!rst) begin
      if (a_ph == 0) begin
        if (a_start) begin a_ph = 1; a_tl = a_target; a_ll = a_lut; end
      end else if (a_ph == l_len + 1) a_ph = 0;
      else a_ph++;
    end
  end

  // ---------------- behavioural model + compare, instance B ----------------
  int         b_ph = 0;
  logic [7:0] b_tl = '0, b_ll = '0, b_emask = '0;
  int         b_efit = 0;
  logic       b_eperf = 1'b0;

  always @(negedge clk) begin : cmp_b
    int l_len;
    int e_chrom;
    l_len = 4;
    if (rst) begin
      b_ph = 0; b_efit = 0; b_eperf = 1'b0; b_emask = '0;
    end else if (b_ph == l_len + 1) begin
      b_emask = b_ll ^ b_tl;
      b_efit  = 8 - $countones(b_emask);
      b_eperf = (b_efit == 8);
    end
    e_chrom = (b_ph >= 1 && b_ph <= l_len) ? b_ph - 1 : 0;
    check("b_chrom_in", 32'(b_chrom_in), e_chrom);
    check("b_busy", 32'(b_busy), 32'(b_ph != 0));
    check("b_done", 32'(b_done), 32'(b_ph == l_len + 1));
    check("b_fitness", 32'(b_fitness), b_efit);
    check("b_perfect", 32'(b_perfect), 32'(b_eperf));
    check("b_state_idle", 32'(b_state == fitness_pkg::IDLE), 32'(b_ph == 0));
`ifdef FITNESS_MASK_EN
    check("b_mask", 32'(b_mask), 32'(b_emask));
`endif
    if (!rst) begin
      if (b_ph == 0) begin
        if (b_start) begin b_ph = 1; b_tl = b_target; b_ll = b_lut; end
      end else if (b_ph == l_len + 1) b_ph = 0;
      else b_ph++;
    end
  end

  // ---------------- driver ----------------
  int          lat;
  logic [31:0] chrom_log[$];

  // Runs one evaluation on instance inst (0=A, 1=B). Entered and left at posedge+1.
  // lat = number of edges from driving start until done is seen.
  // With pulse set, start and target are randomised while the run is busy.
  task automatic run(input int inst, input logic [7:0] tgt, input logic [7:0] lut, input bit pulse);
    int n;
    bit got;
    n = 0;
    while (((inst == 0) ? a_busy : b_busy) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (inst == 0) begin a_target = tgt[3:0]; a_lut = lut[3:0]; a_start = 1'b1; end
    else begin b_target = tgt; b_lut = lut; b_start = 1'b1; end
    chrom_log.delete();
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk); #1; n++;
      chrom_log.push_back(32'((inst == 0) ? a_chrom_in : b_chrom_in));
      got = (inst == 0) ? a_done : b_done;
      if (!got) begin
        if (inst == 0) begin
          a_start = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
          if (pulse) a_target = 4'($urandom);
        end else begin
          b_start = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
          if (pulse) b_target = 8'($urandom);
        end
      end
    end
    a_start = 1'b0;
    b_start = 1'b0;
    check("done_seen", 32'(got), 1);
    lat = n;
  endtask

  int sweep_exp[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1;
    check("reset_fitness", 32'(a_fitness), 0);
    check("reset_busy", 32'(a_busy), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // XOR circuit scored against XOR target, with start pulses during the sweep.
    run(0, 8'h06, 8'h06, 1'b1);
    check("xor_latency", lat, 13);
    check("xor_fitness", 32'(a_fitness), 4);
    check("xor_perfect", 32'(a_perfect), 1);
    check("sweep_len", chrom_log.size(), 13);
    for (int i = 0; i < 13 && i < chrom_log.size(); i++) check("sweep_order", chrom_log[i], sweep_exp[i]);

    // Stuck-at-0 circuit.
    run(0, 8'h06, 8'h00, 1'b0);
    check("stuck_fitness", 32'(a_fitness), 2);
    check("stuck_perfect", 32'(a_perfect), 0);
`ifdef FITNESS_MASK_EN
    check("stuck_mask", 32'(a_mask), 32'h6);
`endif

    // Mid-run reset 5 cycles after start: outputs clear at once, no done.
    @(posedge clk); #1;
    a_target = 4'b0110; a_lut = 4'b0110; a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(a_busy), 0);
    check("rst_chrom_in", 32'(a_chrom_in), 0);
    check("rst_fitness", 32'(a_fitness), 0);
    check("rst_done", 32'(a_done), 0);
    seen = 0;
    repeat (3) begin @(posedge clk); #1; if (a_done) seen++; end
    rst = 1'b0;
    repeat (15) begin @(posedge clk); #1; if (a_done) seen++; end
    check("rst_no_done", seen, 0);
    run(0, 8'h06, 8'h06, 1'b0);
    check("after_rst_latency", lat, 13);
    check("after_rst_fitness", 32'(a_fitness), 4);

    // Zero settle: AND circuit on both output bits, target matches exactly.
    run(1, 8'hC0, 8'hC0, 1'b0);
    check("zero_settle_latency", lat, 5);
    check("zero_settle_fitness", 32'(b_fitness), 8);
    check("zero_settle_perfect", 32'(b_perfect), 1);

    // Multi-output: constant 2'b01 against all-ones target.
    run(1, 8'hFF, 8'h55, 1'b0);
    check("multi_fitness", 32'(b_fitness), 4);
    check("multi_perfect", 32'(b_perfect), 0);
`ifdef FITNESS_MASK_EN
    check("multi_mask", 32'(b_mask), 32'hAA);
`endif

    // Randomised runs on both instances; the per-cycle model checks everything.
    for (int i = 0; i < 30; i++) begin
      run(0, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
      run(1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
